// File: rtl/line_window_pkg.sv
// Shared constants for the 3x3 line window generator.
// Holds window width, buffer count, FSM encoding and window byte offsets.
package line_window_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_W = 9 * DEF_PIX_W;
  localparam int NUM_LINES = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RD_ROW = 1'b1;

  // Byte index of the leftmost pixel of each window row (i = 3*r + c).
  localparam int TOP = 0;
  localparam int MID = 3;
  localparam int BOT = 6;

endpackage

// File: rtl/line_buffer.sv
// One image line of pixel storage.
// Ports: clk, rst, wr_en/wr_col/wr_data (write), rd_en/rd_col -> rd_data
// (registered {col+2, col+1, col} pixels, leftmost in the low bits).
module line_buffer
  import line_window_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W = 8,
  parameter int COL_W = $clog2(IMG_WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [COL_W-1:0]   wr_col,
  input  logic [PIX_W-1:0]   wr_data,
  input  logic               rd_en,
  input  logic [COL_W-1:0]   rd_col,
  output logic [3*PIX_W-1:0] rd_data
);

  logic [PIX_W-1:0] mem [IMG_WIDTH];
  logic [COL_W-1:0] col1;
  logic [COL_W-1:0] col2;

  assign col1 = rd_col + COL_W'(1);
  assign col2 = rd_col + COL_W'(2);

  // Storage itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_col] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= {mem[col2], mem[col1], mem[rd_col]};
    end
  end

endmodule

// File: rtl/line_window_gen.sv
// Buffers a raster pixel stream in four rotating lines and emits 3x3 windows.
// Ports: i_clk, i_rst, i_pixel_data(_valid) in; o_pixel_data(_valid), o_intr out.
module line_window_gen
  import line_window_pkg::*;
#(
  parameter int IMG_WIDTH = 512,
  parameter int PIX_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PIX_W-1:0]   i_pixel_data,
  input  logic               i_pixel_data_valid,
  output logic [9*PIX_W-1:0] o_pixel_data,
  output logic               o_pixel_data_valid,
  output logic               o_intr
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int CNT_W = $clog2(4 * IMG_WIDTH + 1);
  localparam logic [COL_W-1:0] WR_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] RD_LAST = COL_W'(IMG_WIDTH - 3);
  localparam logic [CNT_W-1:0] CNT_LINE = CNT_W'(IMG_WIDTH);
  localparam logic [CNT_W-1:0] CNT_READY = CNT_W'(3 * IMG_WIDTH);

  logic [COL_W-1:0]   wr_col;
  logic [COL_W-1:0]   rd_col;
  logic [1:0]         wr_sel;
  logic [1:0]         rd_sel;
  logic [1:0]         sel_q;
  logic [CNT_W-1:0]   pix_cnt;
  logic [CNT_W-1:0]   pix_nxt;
  logic [0:0]         state;
  logic               rd_en;
  logic               rd_last;
  logic               valid_q;
  logic               intr_q;
  logic [3*PIX_W-1:0] row_data [NUM_LINES];

  assign rd_en = (state == RD_ROW);
  assign rd_last = rd_en && (rd_col == RD_LAST);

  always_comb begin
    pix_nxt = pix_cnt + CNT_W'(i_pixel_data_valid);
    if (rd_last) begin
      pix_nxt = pix_nxt - CNT_LINE;
    end
  end

  for (genvar k = 0; k < NUM_LINES; k++) begin : g_buf
    line_buffer #(
      .IMG_WIDTH(IMG_WIDTH),
      .PIX_W(PIX_W),
      .COL_W(COL_W)
    ) u_buf (
      .clk(i_clk),
      .rst(i_rst),
      .wr_en(i_pixel_data_valid && (wr_sel == 2'(k))),
      .wr_col(wr_col),
      .wr_data(i_pixel_data),
      .rd_en(rd_en),
      .rd_col(rd_col),
      .rd_data(row_data[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_col <= '0;
      wr_sel <= '0;
      rd_col <= '0;
      rd_sel <= '0;
      sel_q <= '0;
      pix_cnt <= '0;
      state <= IDLE;
      valid_q <= 1'b0;
      intr_q <= 1'b0;
    end else begin
      if (i_pixel_data_valid) begin
        if (wr_col == WR_LAST) begin
          wr_col <= '0;
          wr_sel <= wr_sel + 2'd1;
        end else begin
          wr_col <= wr_col + COL_W'(1);
        end
      end
      pix_cnt <= pix_nxt;
      valid_q <= rd_en;
      intr_q <= rd_last;
      // rd_sel may advance on the last read; the mux needs the read's own.
      if (rd_en) begin
        sel_q <= rd_sel;
      end
      unique case (state)
        IDLE: begin
          if (pix_cnt >= CNT_READY) begin
            state <= RD_ROW;
          end
        end
        RD_ROW: begin
          if (rd_last) begin
            rd_col <= '0;
            rd_sel <= rd_sel + 2'd1;
            state <= IDLE;
          end else begin
            rd_col <= rd_col + COL_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rotate the four buffers so rd_sel is always the oldest (top) line.
  always_comb begin
    o_pixel_data = '0;
    o_pixel_data[TOP*PIX_W +: 3*PIX_W] = row_data[sel_q];
    o_pixel_data[MID*PIX_W +: 3*PIX_W] = row_data[sel_q + 2'd1];
    o_pixel_data[BOT*PIX_W +: 3*PIX_W] = row_data[sel_q + 2'd2];
  end

  assign o_pixel_data_valid = valid_q;
  assign o_intr = intr_q;

endmodule

// File: tb/tb_line_window_gen.sv
// Self-checking bench for line_window_gen at IMG_WIDTH=8.
// Directed tables, multi-cycle corner sequences and a random stream model.
module tb_line_window_gen;

  localparam int W = 8;
  localparam int NW = W - 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pv = 1'b0;
  logic [7:0]  pd = '0;
  logic [71:0] od;
  logic        ov;
  logic        oi;

  always #5 clk = ~clk;

  line_window_gen #(.IMG_WIDTH(W), .PIX_W(8)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_pixel_data(pd),
    .i_pixel_data_valid(pv),
    .o_pixel_data(od),
    .o_pixel_data_valid(ov),
    .o_intr(oi)
  );

  typedef struct {
    byte         scen;
    string       name;
    int          idx;
    logic [71:0] exp;
  } vec_t;

  vec_t        tab [$];
  int          tests = 0;
  int          fails = 0;
  logic [71:0] cap [$];
  int          intr_at [$];
  int          intr_bad = 0;
  int          runs = 0;
  logic        ov_prev = 1'b0;
  logic [7:0]  img [0:127];

  always @(negedge clk) begin
    if (ov === 1'b1) begin
      if (!ov_prev) runs++;
      if (oi === 1'b1) intr_at.push_back(cap.size());
      cap.push_back(od);
    end else if (oi === 1'b1) begin
      intr_bad++;
    end
    ov_prev = (ov === 1'b1);
  end

  task automatic clear_mon();
    cap.delete();
    intr_at.delete();
    intr_bad = 0;
    runs = 0;
  endtask

  task automatic chk(string name, logic [71:0] act, logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk_int(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic logic [71:0] exp_win(int k, int c);
    logic [71:0] w;
    w = '0;
    for (int r = 0; r < 3; r++)
      for (int ci = 0; ci < 3; ci++)
        w[(3*r+ci)*8 +: 8] = img[(k+r)*W + c + ci];
    return w;
  endfunction

  function automatic logic [71:0] cap_at(int i);
    if (i < cap.size()) return cap[i];
    return 'x;
  endfunction

  function automatic int intr_pos(int i);
    if (i < intr_at.size()) return intr_at[i];
    return -1;
  endfunction

  task automatic cyc(logic v, logic [7:0] d);
    @(posedge clk);
    #1;
    pv = v;
    pd = d;
  endtask

  task automatic idle(int n);
    repeat (n) cyc(1'b0, 8'h00);
  endtask

  // mode 0: valid held high, 1: every other cycle, 2: random gaps
  task automatic send_line(int ln, int mode);
    for (int c = 0; c < W; c++) begin
      if (mode == 1) cyc(1'b0, 8'h00);
      if (mode == 2 && $urandom_range(0, 2) == 0) cyc(1'b0, 8'h00);
      cyc(1'b1, img[ln*W + c]);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    pv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    clear_mon();
    chk("rst_data", od, '0);
    chk_int("rst_valid", int'(ov), 0);
    chk_int("rst_intr", int'(oi), 0);
  endtask

  task automatic fill_id();
    for (int i = 0; i < 128; i++) img[i] = 8'(i);
  endtask

  task automatic chk_rows(string tag, int nrows);
    for (int k = 0; k < nrows; k++)
      for (int c = 0; c < NW; c++)
        chk($sformatf("%s_r%0d_c%0d", tag, k, c),
            cap_at(k*NW + c), exp_win(k, c));
  endtask

  task automatic apply_tab(byte s);
    foreach (tab[i])
      if (tab[i].scen == s)
        chk(tab[i].name, cap_at(tab[i].idx), tab[i].exp);
  endtask

  task automatic run_a(int mode);
    do_reset();
    fill_id();
    send_line(0, mode);
    send_line(1, mode);
    idle(20);
    chk_int("a_pre_count", cap.size(), 0);
    chk_int("a_pre_intr", intr_at.size() + intr_bad, 0);
    send_line(2, mode);
    idle(20);
    chk_int("a_row1_count", cap.size(), NW);
    chk_int("a_row1_intr", intr_at.size(), 1);
    chk_int("a_row1_intr_pos", intr_pos(0), NW - 1);
    chk_int("a_row1_runs", runs, 1);
    send_line(3, mode);
    idle(20);
    chk_int("a_row2_count", cap.size(), 2*NW);
    chk_int("a_row2_intr", intr_at.size(), 2);
    chk_int("a_row2_intr_pos", intr_pos(1), 2*NW - 1);
    chk_int("a_runs", runs, 2);
    chk_int("a_intr_bad", intr_bad, 0);
    chk_rows("a", 2);
    apply_tab("A");
  endtask

  task automatic run_b(int mode);
    do_reset();
    fill_id();
    for (int ln = 0; ln < 6; ln++) send_line(ln, mode);
    idle(40);
    chk_int("b_count", cap.size(), 4*NW);
    chk_int("b_intr", intr_at.size(), 4);
    chk_int("b_runs", runs, 4);
    chk_int("b_intr_bad", intr_bad, 0);
    for (int r = 0; r < 4; r++)
      chk_int($sformatf("b_intr_pos%0d", r), intr_pos(r), r*NW + NW - 1);
    chk_rows("b", 4);
    apply_tab("B");
  endtask

  task automatic run_mid_reset();
    bit found;
    do_reset();
    fill_id();
    for (int ln = 0; ln < 3; ln++) send_line(ln, 0);
    cyc(1'b0, 8'h00);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      #1;
      if (cap.size() >= 3) found = 1;
    end
    chk_int("d_third_window_seen", int'(found), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_int("d_valid_after_rst", int'(ov), 0);
    idle(20);
    chk_int("d_count_after_rst", cap.size(), 3);
    chk_int("d_intr_after_rst", intr_at.size() + intr_bad, 0);
    clear_mon();
    for (int ln = 0; ln < 3; ln++) send_line(ln, 0);
    idle(20);
    chk_int("d_fresh_count", cap.size(), NW);
    chk_int("d_fresh_intr_pos", intr_pos(0), NW - 1);
    chk_rows("d", 1);
  endtask

  task automatic run_random();
    localparam int L = 10;
    bit ok;
    do_reset();
    for (int i = 0; i < 128; i++) img[i] = 8'($urandom);
    for (int ln = 0; ln < L; ln++) begin
      ok = 1;
      for (int b = 0; (ln - intr_at.size()) >= 4; b++) begin
        if (b > 200) begin
          ok = 0;
          break;
        end
        cyc(1'b0, 8'h00);
      end
      if (!ok) begin
        chk_int("e_throttle_timeout", 1, 0);
        break;
      end
      send_line(ln, 2);
    end
    idle(60);
    chk_int("e_count", cap.size(), (L-2)*NW);
    chk_int("e_intr", intr_at.size(), L-2);
    chk_int("e_runs", runs, L-2);
    chk_int("e_intr_bad", intr_bad, 0);
    chk_rows("e", L-2);
  endtask

  initial begin
    tab.push_back('{"A", "a_first_window", 0,
      {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}});
    tab.push_back('{"A", "a_last_window", NW - 1,
      {8'd23, 8'd22, 8'd21, 8'd15, 8'd14, 8'd13, 8'd7, 8'd6, 8'd5}});
    tab.push_back('{"A", "a_row2_first", NW,
      {8'd26, 8'd25, 8'd24, 8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8}});
    tab.push_back('{"B", "b_row1_first", 0,
      {8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}});
    tab.push_back('{"B", "b_row4_first", 3*NW,
      {8'd42, 8'd41, 8'd40, 8'd34, 8'd33, 8'd32, 8'd26, 8'd25, 8'd24}});
    tab.push_back('{"B", "b_row4_last", 4*NW - 1,
      {8'd47, 8'd46, 8'd45, 8'd39, 8'd38, 8'd37, 8'd31, 8'd30, 8'd29}});

    run_a(0);
    run_b(0);
    run_a(1);
    run_b(1);
    run_mid_reset();
    run_random();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
